sum_display_driver: RTL and testbench
=====================================

Name: sum_display_driver

Overview:
- Output-side counterpart of the keypad input path: accepts a binary result (e.g. Num1+Num2 on Sum_ready) through a load handshake.
- Converts the result to BCD serially (shift-add-3) and drives a 4-digit multiplexed common-anode 7-segment display.
- Sits between the keypad-reading block and board pins.

Parameters:
- WIDTH, 11, bit width of Value; legal range 4..14.
- REFRESH_DIV, 27000, clock cycles each digit stays lit (1 ms at 27 MHz); must be >= 2.

Ports:
- clock  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- Value  input  WIDTH  unsigned binary value to display.
- Load  input  1  single-cycle request to capture Value.
- Busy  output  1  high while a conversion is in progress.
- Anode  output  4  digit enables, active-low, one-hot; bit 0 is the units digit.
- Segments  output  7  gfedcba, active-low (bit 6 = g).

Behaviour:
- Reset (async, immediate):
  - Busy=0; digit registers = 0,0,0,0; scan index=0; refresh counter=0.
  - Anode=4'b1110; Segments=7'b1000000 ('0').
- Handshake:
  - Load sampled only when Busy=0; Value captured that edge; Busy=1 from next cycle.
  - Load while Busy=1 is ignored (no queueing), including on the commit cycle.
- Conversion FSM, states IDLE -> SHIFT -> COMMIT -> IDLE:
  - SHIFT runs exactly WIDTH cycles. Each cycle: add 3 to every BCD nibble >= 5, then shift {BCD,bin} left by 1.
  - COMMIT lasts 1 cycle: digit registers load the result and Busy falls.
  - Busy is high exactly WIDTH+1 cycles per accepted Load.
- Overflow:
  - If the captured Value > 9999 (only possible when WIDTH >= 14), COMMIT loads the dash code into all four digits.
  - Latency is unchanged.
- Display registers hold their contents until the next COMMIT or reset.
- Scan:
  - Refresh counter counts 0..REFRESH_DIV-1 continuously, independent of the FSM.
  - At terminal count: counter wraps to 0 and scan index advances 0->1->2->3->0.
  - Anode and Segments are registered and reflect the index and digit registers with 1-cycle latency.
  - A COMMIT mid-scan shows the new digit on the next output update; no glitch beyond that one cycle.
- Leading-zero blanking:
  - Digit k (k = 1..3) shows blank (7'b1111111) when it and all higher digits are 0.
  - Digit 0 is never blanked.
  - Dashes are never blanked.
  - Anode still selects blanked digits (constant duty cycle).
- Segment codes (gfedcba, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - dash=0111111, blank=1111111.
- Reset asserted mid-conversion aborts it: FSM returns to IDLE, display returns to '0', and the partial result is discarded.

Test Plan:
1. Reset with REFRESH_DIV=4 -> Anode=1110, Segments=1000000. Then after the index advances: Anode=1101 with Segments=1111111, Anode=1011 blank, Anode=0111 blank, back to 1110.
2. Load Value=1998 (WIDTH=11) -> Busy high exactly 12 cycles, then the scan shows:
   - digit0 = 8 (0000000)
   - digit1 = 9 (0010000)
   - digit2 = 9 (0010000)
   - digit3 = 1 (1111001)
3. Load Value=7 -> digit0 shows 1111000; digits 1-3 show 1111111; Load Value=1000 afterwards -> digits 0001 with no blanking (1000000 x3, digit3 1111001).
4. Load 55, then pulse Load with 999 on cycles 3 and 12 after the first Load (cycle 12 = commit cycle) -> both ignored, display shows 55, Busy low after 12 cycles.
5. WIDTH=14 instance, Load Value=12000 -> after 15 cycles all digits show 0111111; then Load 9999 -> 9,9,9,9.
6. Load 1234, assert reset 5 cycles later for 2 cycles -> Busy=0 immediately, display shows '0'. A new Load 42 accepted on the first cycle after reset release, giving digits 2,4 and two blanks.

Source files
------------

// File: rtl/sum_display_driver.sv
// sum_display_driver
// Captures a binary result through a Load/Busy handshake, converts it to BCD
// one bit per cycle (shift-add-3), and scans the four digits onto a
// common-anode 7-segment display with leading-zero blanking. Values above
// 9999 are shown as four dashes.

module sum_display_driver #(
   parameter int WIDTH       = 11,     // bit width of Value, 4..14
   parameter int REFRESH_DIV = 27000   // cycles each digit stays lit, >= 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] Value,
   input  logic             Load,
   output logic             Busy,
   output logic [3:0]       Anode,
   output logic [6:0]       Segments
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam int REF_W = $clog2(REFRESH_DIV);

   // Internal digit code for the dash; 0..9 are plain BCD.
   localparam logic [3:0] DIGIT_DASH = 4'hA;

   localparam logic [6:0] SEG_ZERO  = 7'b1000000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      COMMIT
   } state_t;

   state_t            state;
   state_t            state_next;

   logic [WIDTH-1:0]  bin_q;        // binary bits still to be shifted in
   logic [15:0]       bcd_q;        // four BCD nibbles being built
   logic [15:0]       bcd_adj;      // bcd_q after the add-3 correction
   logic [CNT_W-1:0]  bit_cnt;      // shift steps completed
   logic              ovf_q;        // captured value does not fit in 4 digits
   logic              value_ovf;

   logic [3:0][3:0]   digit_q;      // displayed digits, [0] = units

   logic [REF_W-1:0]  refresh_cnt;
   logic [1:0]        scan_idx;

   logic [3:0]        sel_digit;
   logic              blank;
   logic [3:0]        anode_next;
   logic [6:0]        seg_next;

   // Active-low gfedcba pattern for one digit code.
   function automatic logic [6:0] seg_encode(input logic [3:0] d);
      logic [6:0] s;
      unique case (d)
         4'd0:       s = 7'b1000000;
         4'd1:       s = 7'b1111001;
         4'd2:       s = 7'b0100100;
         4'd3:       s = 7'b0110000;
         4'd4:       s = 7'b0011001;
         4'd5:       s = 7'b0010010;
         4'd6:       s = 7'b0000010;
         4'd7:       s = 7'b1111000;
         4'd8:       s = 7'b0000000;
         4'd9:       s = 7'b0010000;
         DIGIT_DASH: s = 7'b0111111;
         default:    s = SEG_BLANK;
      endcase
      return s;
   endfunction

   // The overflow decision is taken on the raw input so the shifter itself
   // only ever has to produce four digits.
   assign value_ovf = (32'(Value) > 32'd9999);

   assign Busy = (state != IDLE);

   // State register for the conversion FSM.
   always_ff @(posedge clock or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values of its neighbours, matching the hardware.
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Next-state logic: IDLE -> SHIFT (WIDTH cycles) -> COMMIT (1 cycle) -> IDLE.
   always_comb begin
      // NOTE: assigning a default before the case keeps every path covered,
      // so no latch can be inferred when a branch leaves the signal alone.
      state_next = state;
      unique case (state)
         IDLE:    if (Load) state_next = SHIFT;
         SHIFT:   if (bit_cnt == CNT_W'(WIDTH - 1)) state_next = COMMIT;
         COMMIT:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Add-3 correction on every nibble that would overflow past 9 when doubled.
   always_comb begin
      bcd_adj = bcd_q;
      for (int n = 0; n < 4; n++) begin
         if (bcd_q[4*n +: 4] >= 4'd5) bcd_adj[4*n +: 4] = bcd_q[4*n +: 4] + 4'd3;
      end
   end

   // Conversion datapath: capture on an accepted Load, then shift once per cycle.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         bin_q   <= '0;
         bcd_q   <= '0;
         bit_cnt <= '0;
         ovf_q   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (Load) begin
                  bin_q   <= Value;
                  bcd_q   <= '0;
                  bit_cnt <= '0;
                  ovf_q   <= value_ovf;
               end
            end
            SHIFT: begin
               {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
               bit_cnt        <= bit_cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Digit registers: updated only on COMMIT, otherwise they hold.
   always_ff @(posedge clock or posedge reset) begin
      // NOTE: this small register array is reset on purpose; the display must
      // read '0' immediately after reset, so it cannot be left uninitialised
      // like a RAM would be.
      if (reset) begin
         digit_q <= '0;
      end else if (state == COMMIT) begin
         for (int n = 0; n < 4; n++) begin
            digit_q[n] <= ovf_q ? DIGIT_DASH : bcd_q[4*n +: 4];
         end
      end
   end

   // Free-running refresh divider and scan index, independent of the FSM.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         refresh_cnt <= '0;
         scan_idx    <= 2'd0;
      end else if (refresh_cnt == REF_W'(REFRESH_DIV - 1)) begin
         refresh_cnt <= '0;
         scan_idx    <= scan_idx + 2'd1;
      end else begin
         refresh_cnt <= refresh_cnt + 1'b1;
      end
   end

   // Leading-zero blanking for the selected digit; dashes are non-zero codes
   // and therefore never blank.
   always_comb begin
      blank = 1'b0;
      unique case (scan_idx)
         2'd1:    blank = (digit_q[1] == 4'd0) && (digit_q[2] == 4'd0) && (digit_q[3] == 4'd0);
         2'd2:    blank = (digit_q[2] == 4'd0) && (digit_q[3] == 4'd0);
         2'd3:    blank = (digit_q[3] == 4'd0);
         default: blank = 1'b0;
      endcase
   end

   // Pattern and digit enable for the currently scanned position.
   always_comb begin
      sel_digit  = digit_q[scan_idx];
      anode_next = ~(4'b0001 << scan_idx);
      seg_next   = blank ? SEG_BLANK : seg_encode(sel_digit);
   end

   // Registered pin drivers, one cycle behind the scan index and digits.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         Anode    <= 4'b1110;
         Segments <= SEG_ZERO;
      end else begin
         Anode    <= anode_next;
         Segments <= seg_next;
      end
   end

endmodule

// File: tb/tb_sum_display_driver.sv
// Testbench for sum_display_driver: a WIDTH=11 and a WIDTH=14 instance share
// clock and reset; expected display content is derived from decimal
// arithmetic on the loaded value.

module tb_sum_display_driver;

   localparam int RD = 4;

   logic        clock = 1'b0;
   logic        reset;

   logic [10:0] value_a;
   logic        load_a;
   logic        busy_a;
   logic [3:0]  anode_a;
   logic [6:0]  seg_a;

   logic [13:0] value_b;
   logic        load_b;
   logic        busy_b;
   logic [3:0]  anode_b;
   logic [6:0]  seg_b;

   int n_checks = 0;
   int n_fail   = 0;

   sum_display_driver #(.WIDTH(11), .REFRESH_DIV(RD)) dut_a (
      .clock    (clock),
      .reset    (reset),
      .Value    (value_a),
      .Load     (load_a),
      .Busy     (busy_a),
      .Anode    (anode_a),
      .Segments (seg_a)
   );

   sum_display_driver #(.WIDTH(14), .REFRESH_DIV(RD)) dut_b (
      .clock    (clock),
      .reset    (reset),
      .Value    (value_b),
      .Load     (load_b),
      .Busy     (busy_b),
      .Anode    (anode_b),
      .Segments (seg_b)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference segment table.
   function automatic logic [6:0] seg_of(input int d);
      case (d)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         9: return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   // Expected pattern for decimal position idx of value v.
   function automatic logic [6:0] exp_seg(input int v, input int idx);
      int div = 1;
      if (v > 9999) return 7'b0111111;
      for (int i = 0; i < idx; i++) div = div * 10;
      if (idx > 0 && (v / div) == 0) return 7'b1111111;
      return seg_of((v / div) % 10);
   endfunction

   function automatic int idx_of(input logic [3:0] an);
      case (an)
         4'b1110: return 0;
         4'b1101: return 1;
         4'b1011: return 2;
         4'b0111: return 3;
         default: return -1;
      endcase
   endfunction

   task automatic get(input bit sel, output logic busy, output logic [3:0] an, output logic [6:0] sg);
      busy = sel ? busy_b  : busy_a;
      an   = sel ? anode_b : anode_a;
      sg   = sel ? seg_b   : seg_a;
   endtask

   task automatic drive(input bit sel, input int v, input bit ld);
      if (sel) begin
         value_b = 14'(v);
         load_b  = ld;
      end else begin
         value_a = 11'(v);
         load_a  = ld;
      end
   endtask

   // Called at a negedge: pulse Load for one edge, then count Busy cycles.
   task automatic do_load(input bit sel, input int v, input string tag);
      logic       b;
      logic [3:0] an;
      logic [6:0] sg;
      int         n = 0;
      drive(sel, v, 1'b1);
      @(posedge clock);
      @(negedge clock);
      drive(sel, v, 1'b0);
      get(sel, b, an, sg);
      while (b === 1'b1 && n < 100) begin
         n++;
         @(negedge clock);
         get(sel, b, an, sg);
      end
      check({tag, "_busy_cycles"}, 32'(n), sel ? 32'd15 : 32'd12);
   endtask

   // Watch a full scan rotation and compare each lit digit with the model.
   task automatic check_display(input bit sel, input int v, input string tag);
      logic       b;
      logic [3:0] an;
      logic [6:0] sg;
      logic [3:0] seen = 4'b0000;
      int         idx;
      @(negedge clock);
      for (int i = 0; i < 4 * RD + 2; i++) begin
         get(sel, b, an, sg);
         idx = idx_of(an);
         if (idx < 0) begin
            check({tag, "_anode_onehot"}, 32'(an), 32'hE);
         end else begin
            seen[idx] = 1'b1;
            check($sformatf("%s_seg_d%0d", tag, idx), 32'(sg), 32'(exp_seg(v, idx)));
         end
         @(negedge clock);
      end
      check({tag, "_all_digits_scanned"}, 32'(seen), 32'hF);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] ea;
      int         eidx;
      int         n;
      int         v;

      reset   = 1'b1;
      value_a = '0;
      load_a  = 1'b0;
      value_b = '0;
      load_b  = 1'b0;

      // Test 1: reset state and blank scan of an all-zero display.
      repeat (3) @(negedge clock);
      check("rst_busy_a",  32'(busy_a),  32'd0);
      check("rst_anode_a", 32'(anode_a), 32'hE);
      check("rst_seg_a",   32'(seg_a),   32'h40);
      check("rst_busy_b",  32'(busy_b),  32'd0);
      check("rst_anode_b", 32'(anode_b), 32'hE);
      check("rst_seg_b",   32'(seg_b),   32'h40);
      reset = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clock);
         @(negedge clock);
         eidx = ((k - 1) / RD) % 4;
         ea = 4'b1111;
         ea[eidx] = 1'b0;
         check($sformatf("scan_anode_k%0d", k), 32'(anode_a), 32'(ea));
         check($sformatf("scan_seg_k%0d", k), 32'(seg_a), eidx == 0 ? 32'h40 : 32'h7F);
      end

      // Test 2: 1998 on the 11-bit instance.
      do_load(1'b0, 1998, "t2");
      check_display(1'b0, 1998, "t2");

      // Test 3: leading-zero blanking, then interior zeros not blanked.
      do_load(1'b0, 7, "t3a");
      check_display(1'b0, 7, "t3a");
      do_load(1'b0, 1000, "t3b");
      check_display(1'b0, 1000, "t3b");

      // Test 4: Loads during conversion, including the commit cycle, are ignored.
      drive(1'b0, 55, 1'b1);
      @(posedge clock);
      n = 0;
      for (int c = 1; c <= 14; c++) begin
         @(negedge clock);
         if (busy_a === 1'b1) n++;
         drive(1'b0, (c == 3 || c == 12) ? 999 : 55, (c == 3 || c == 12));
         @(posedge clock);
      end
      @(negedge clock);
      drive(1'b0, 0, 1'b0);
      check("t4_busy_cycles", 32'(n), 32'd12);
      check("t4_busy_after",  32'(busy_a), 32'd0);
      check_display(1'b0, 55, "t4");

      // Test 5: overflow to dashes on the 14-bit instance, and the 9999 boundary.
      do_load(1'b1, 12000, "t5a");
      check_display(1'b1, 12000, "t5a");
      do_load(1'b1, 9999, "t5b");
      check_display(1'b1, 9999, "t5b");
      do_load(1'b1, 10000, "t5c");
      check_display(1'b1, 10000, "t5c");

      // Test 6: reset mid-conversion aborts it; Load right after release works.
      drive(1'b0, 1234, 1'b1);
      @(posedge clock);
      @(negedge clock);
      drive(1'b0, 1234, 1'b0);
      repeat (4) @(negedge clock);
      check("t6_busy_mid", 32'(busy_a), 32'd1);
      reset = 1'b1;
      #1;
      check("t6_rst_busy",  32'(busy_a),  32'd0);
      check("t6_rst_anode", 32'(anode_a), 32'hE);
      check("t6_rst_seg",   32'(seg_a),   32'h40);
      repeat (2) @(negedge clock);
      reset = 1'b0;
      do_load(1'b0, 42, "t6");
      check_display(1'b0, 42, "t6");

      // Randomised values on both instances, including the 14-bit overflow range.
      for (int i = 0; i < 6; i++) begin
         v = int'($urandom_range(0, 2047));
         do_load(1'b0, v, $sformatf("rnd_a%0d_%0d", i, v));
         check_display(1'b0, v, $sformatf("rnd_a%0d_%0d", i, v));
         v = int'($urandom_range(0, 16383));
         do_load(1'b1, v, $sformatf("rnd_b%0d_%0d", i, v));
         check_display(1'b1, v, $sformatf("rnd_b%0d_%0d", i, v));
      end
      do_load(1'b0, 2047, "max_a");
      check_display(1'b0, 2047, "max_a");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
